// File: rtl/pipelined_shifter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_shifter_core / pipelined_shifter_arbiter
//  Purpose  : Round-robin sharing of one fixed-latency barrel shifter between
//             NREQ requesters. Each result returns on one shared response port,
//             tagged with the ID of its requester. Requests are credit-gated so
//             that the response FIFO can never overflow while the consumer
//             applies backpressure.
//  Ports (arbiter):
//    clk, rst_n                 clock, asynchronous active-low reset
//    req_valid_i/req_ready_o    per-requester handshake (ready one-hot or zero)
//    req_opcode_i               2 bits/requester: 00 SLL, 01 SRL, 10 SRA, 11 illegal
//    req_shamt_i, req_data_i    STAGES / WIDTH bits per requester
//    rsp_valid_o/rsp_ready_i    response handshake (FIFO head)
//    rsp_data_o, rsp_id_o       shifted result, originating requester index
//    rsp_err_o                  request carried opcode 11
//    busy_o                     work in flight or queued
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Shifter core: input register, one register per log2 shift stage, output
// register => STAGES+2 cycles of latency. Not reset; validity is tracked
// outside. Each stage's select is split into BLOCK-bit mux slices.
// ----------------------------------------------------------------------------
module pipelined_shifter_core #(
  parameter  int WIDTH  = 32,
  parameter  int BLOCK  = 16,
  localparam int STAGES = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              v_in_i,
  input  logic [1:0]        opcode_i,
  input  logic [STAGES-1:0] shamt_i,
  input  logic [WIDTH-1:0]  din_i,
  output logic [WIDTH-1:0]  dout_o
);
  localparam int NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0]  data_q  [STAGES+1];
  logic [STAGES-1:0] shamt_q [STAGES];
  logic              left_q  [STAGES];
  // Bit shifted in from the top on right shifts: sign for SRA, 0 for SRL.
  logic              fill_q  [STAGES];
  logic [WIDTH-1:0]  dout_q;
  logic [WIDTH-1:0]  w_stage_d [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SH = 1 << k;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_srx;
    assign w_sll = data_q[k] << SH;
    assign w_srx = {{SH{fill_q[k]}}, data_q[k][WIDTH-1:SH]};
    for (genvar b = 0; b < NBLK; b++) begin : g_blk
      assign w_stage_d[k][b*BLOCK +: BLOCK] =
        !shamt_q[k][k] ? data_q[k][b*BLOCK +: BLOCK] :
        left_q[k]      ? w_sll[b*BLOCK +: BLOCK]     :
                         w_srx[b*BLOCK +: BLOCK];
    end
  end

  always_ff @(posedge clk) begin
    if (v_in_i) begin
      data_q[0]  <= din_i;
      shamt_q[0] <= shamt_i;
      left_q[0]  <= (opcode_i == 2'b00);
      fill_q[0]  <= (opcode_i == 2'b10) & din_i[WIDTH-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      data_q[k+1] <= w_stage_d[k];
    end
    for (int k = 0; k < STAGES-1; k++) begin
      shamt_q[k+1] <= shamt_q[k];
      left_q[k+1]  <= left_q[k];
      fill_q[k+1]  <= fill_q[k];
    end
    dout_q <= data_q[STAGES];
  end

  assign dout_o = dout_q;
endmodule

// ----------------------------------------------------------------------------
// Arbiter top
// ----------------------------------------------------------------------------
module pipelined_shifter_arbiter #(
  parameter  int WIDTH      = 32,
  parameter  int BLOCK      = 16,
  parameter  int NREQ       = 4,
  parameter  int FIFO_DEPTH = 8,
  localparam int STAGES     = $clog2(WIDTH),
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [2*NREQ-1:0]      req_opcode_i,
  input  logic [STAGES*NREQ-1:0] req_shamt_i,
  input  logic [WIDTH*NREQ-1:0]  req_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [WIDTH-1:0]       rsp_data_o,
  output logic [IDW-1:0]         rsp_id_o,
  output logic                   rsp_err_o,
  output logic                   busy_o
);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int TAGN = STAGES + 2;
  localparam logic [CNTW:0] DEPTH_W = (CNTW+1)'(FIFO_DEPTH);

  // ---------------- state ----------------
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0]  inflight_q, inflight_d;
  logic [CNTW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             tag_v_q   [TAGN];
  logic [IDW-1:0]   tag_id_q  [TAGN];
  logic             tag_err_q [TAGN];
  logic [WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [IDW-1:0]   fifo_id_q   [FIFO_DEPTH];
  logic             fifo_err_q  [FIFO_DEPTH];

  // ---------------- combinational ----------------
  logic              w_gnt_any;
  logic [IDW-1:0]    w_gnt_idx;
  logic [IDW-1:0]    w_cand;
  logic              w_credit_ok;
  logic              w_accept;
  logic [1:0]        w_op;
  logic [STAGES-1:0] w_shamt;
  logic [WIDTH-1:0]  w_din;
  logic              w_err;
  logic [1:0]        w_core_op;
  logic [WIDTH-1:0]  w_core_dout;
  logic              w_push;
  logic              w_pop;

  // Circular search starting just after the last accepted requester.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!w_gnt_any && req_valid_i[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Credits cover both results still in the core and results queued, so a
  // result leaving the core always finds a free FIFO slot.
  assign w_credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < DEPTH_W;
  assign w_accept    = w_gnt_any & w_credit_ok;
  assign req_ready_o = w_accept ? (NREQ'(1) << w_gnt_idx) : '0;

  always_comb begin
    w_op    = 2'b00;
    w_shamt = '0;
    w_din   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == IDW'(i)) begin
        w_op    = req_opcode_i[2*i +: 2];
        w_shamt = req_shamt_i[STAGES*i +: STAGES];
        w_din   = req_data_i[WIDTH*i +: WIDTH];
      end
    end
  end

  // Illegal opcode still produces a result (as SRL) but is flagged.
  assign w_err     = (w_op == 2'b11);
  assign w_core_op = w_err ? 2'b01 : w_op;

  pipelined_shifter_core #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK)
  ) u_core (
    .clk      (clk),
    .v_in_i   (w_accept),
    .opcode_i (w_core_op),
    .shamt_i  (w_shamt),
    .din_i    (w_din),
    .dout_o   (w_core_dout)
  );

  // Tag pipe runs parallel to the core; its last stage lines up with dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAGN; k++) begin
        tag_v_q[k]   <= 1'b0;
        tag_id_q[k]  <= '0;
        tag_err_q[k] <= 1'b0;
      end
    end else begin
      tag_v_q[0]   <= w_accept;
      tag_id_q[0]  <= w_gnt_idx;
      tag_err_q[0] <= w_err;
      for (int k = 1; k < TAGN; k++) begin
        tag_v_q[k]   <= tag_v_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
        tag_err_q[k] <= tag_err_q[k-1];
      end
    end
  end

  assign w_push = tag_v_q[TAGN-1];
  assign w_pop  = (fifo_cnt_q != '0) & rsp_ready_i;

  assign ptr_d      = w_accept ? w_gnt_idx : ptr_q;
  assign inflight_d = inflight_q + CNTW'(w_accept) - CNTW'(w_push);
  assign fifo_cnt_d = fifo_cnt_q + CNTW'(w_push) - CNTW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= IDW'(NREQ - 1);
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
    end
  end

  // Storage needs no reset: entries are only visible through fifo_cnt_q.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_data_q[wr_ptr_q] <= w_core_dout;
      fifo_id_q[wr_ptr_q]   <= tag_id_q[TAGN-1];
      fifo_err_q[wr_ptr_q]  <= tag_err_q[TAGN-1];
    end
  end

  // Head fields are forced to zero when empty so reset/idle outputs are clean.
  assign rsp_valid_o = (fifo_cnt_q != '0);
  assign rsp_data_o  = rsp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_id_o    = rsp_valid_o ? fifo_id_q[rd_ptr_q]   : '0;
  assign rsp_err_o   = rsp_valid_o ? fifo_err_q[rd_ptr_q]  : 1'b0;
  assign busy_o      = (inflight_q != '0) | (fifo_cnt_q != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (fifo_cnt_q == CNTW'(FIFO_DEPTH))));
endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter_arbiter.sv
`default_nettype none
module tb_pipelined_shifter_arbiter;
  localparam int WIDTH  = 32;
  localparam int NREQ   = 4;
  localparam int STAGES = 5;
  localparam int DEPTH  = 8;
  localparam int LAT    = STAGES + 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [2*NREQ-1:0]      req_opcode = '0;
  logic [STAGES*NREQ-1:0] req_shamt = '0;
  logic [WIDTH*NREQ-1:0]  req_data = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [WIDTH-1:0]       rsp_data;
  logic [1:0]             rsp_id;
  logic                   rsp_err;
  logic                   busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_shifter_arbiter #(
    .WIDTH(WIDTH), .BLOCK(16), .NREQ(NREQ), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opcode_i(req_opcode), .req_shamt_i(req_shamt), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err),
    .busy_o(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Behavioural shift reference straight from the opcode definitions.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op, input int sh,
                                                 input logic [WIDTH-1:0] d);
    case (op)
      2'b00:   return d << sh;
      2'b10:   return WIDTH'($signed(d) >>> sh);
      default: return d >> sh;
    endcase
  endfunction

  // ---------------- scoreboard model ----------------
  typedef struct {
    logic [WIDTH-1:0] data;
    int               id;
    logic             err;
    longint           ready_at;
  } exp_t;

  exp_t            mq[$];
  int              acc_log[$];
  int              m_ptr = NREQ - 1;
  longint          cyc = 0;
  logic [NREQ-1:0] acc_mask = '0;
  logic [NREQ-1:0] exp_ready;
  logic            found;
  int              gi;
  int              rsp_seen = 0;
  exp_t            e;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_data", rsp_data, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_rsp_err", rsp_err, 0);
      check("reset_busy", busy, 0);
      mq.delete();
      m_ptr    = NREQ - 1;
      acc_mask = '0;
    end else begin
      exp_ready = '0;
      found     = 1'b0;
      if (mq.size() < DEPTH) begin
        for (int k = 1; k <= NREQ; k++) begin
          gi = (m_ptr + k) % NREQ;
          if (!found && req_valid[gi]) begin
            found         = 1'b1;
            exp_ready[gi] = 1'b1;
          end
        end
      end
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, mq.size() != 0);
      check("rsp_valid", rsp_valid, (mq.size() > 0) && (mq[0].ready_at <= cyc));
      if (rsp_valid && rsp_ready) begin
        if (mq.size() == 0) begin
          check("rsp_spurious", rsp_valid, 1'b0);
        end else begin
          check("rsp_data", rsp_data, mq[0].data);
          check("rsp_id", rsp_id, mq[0].id);
          check("rsp_err", rsp_err, mq[0].err);
          void'(mq.pop_front());
          rsp_seen++;
        end
      end
      acc_mask = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          e.data     = ref_shift(req_opcode[2*i +: 2], int'(req_shamt[STAGES*i +: STAGES]),
                                 req_data[WIDTH*i +: WIDTH]);
          e.id       = i;
          e.err      = (req_opcode[2*i +: 2] == 2'b11);
          e.ready_at = cyc + LAT + 1;
          mq.push_back(e);
          m_ptr = i;
          acc_log.push_back(i);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [STAGES-1:0] sh, input logic [WIDTH-1:0] d);
    req_valid[i]               = v;
    req_opcode[2*i +: 2]       = op;
    req_shamt[STAGES*i +: STAGES] = sh;
    req_data[WIDTH*i +: WIDTH] = d;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  typedef struct {
    logic [1:0]  op;
    int          sh;
    logic [31:0] d;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t tbl[9];

  initial begin : main
    int n, lat, s0, a0, vseen;
    bit phase;

    tbl[0] = '{op:2'b00, sh:4,  d:32'h0000_0001, res:32'h0000_0010, err:1'b0};
    tbl[1] = '{op:2'b10, sh:31, d:32'h8000_0000, res:32'hFFFF_FFFF, err:1'b0};
    tbl[2] = '{op:2'b01, sh:31, d:32'h8000_0000, res:32'h0000_0001, err:1'b0};
    tbl[3] = '{op:2'b11, sh:31, d:32'h8000_0000, res:32'h0000_0001, err:1'b1};
    tbl[4] = '{op:2'b00, sh:0,  d:32'hA5A5_A5A5, res:32'hA5A5_A5A5, err:1'b0};
    tbl[5] = '{op:2'b01, sh:28, d:32'hF000_0000, res:32'h0000_000F, err:1'b0};
    tbl[6] = '{op:2'b00, sh:31, d:32'hFFFF_FFFF, res:32'h8000_0000, err:1'b0};
    tbl[7] = '{op:2'b10, sh:30, d:32'h7FFF_FFFF, res:32'h0000_0001, err:1'b0};
    tbl[8] = '{op:2'b10, sh:4,  d:32'h8000_0010, res:32'hF800_0001, err:1'b0};

    #1;
    do_reset();

    // --- directed vectors through requester 0: value and latency ---
    rsp_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      set_req(0, 1'b1, tbl[v].op, STAGES'(tbl[v].sh), tbl[v].d);
      n = 0;
      @(negedge clk);
      while (!req_ready[0] && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("tbl_accept", req_ready[0], 1);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
        tick();
        lat++;
      end
      check("tbl_latency", lat, LAT);
      check("tbl_data", rsp_data, tbl[v].res);
      check("tbl_id", rsp_id, 0);
      check("tbl_err", rsp_err, tbl[v].err);
      tick();
    end
    wait_idle("tbl_idle");

    // --- all requesters valid: round-robin order from reset ---
    do_reset();
    rsp_ready = 1'b1;
    acc_log.delete();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 2'($urandom_range(0, 2)), STAGES'($urandom), $urandom);
    repeat (12) tick();
    req_valid = '0;
    check("rr_count", acc_log.size() >= 8, 1);
    for (int k = 0; k < 8; k++) check("rr_order", acc_log[k], k % NREQ);
    wait_idle("rr_idle");

    // --- credit limit with consumer stalled ---
    do_reset();
    acc_log.delete();
    set_req(0, 1'b1, 2'b00, 5'd1, 32'h3);
    repeat (20) tick();
    check("credit_accepts", acc_log.size(), DEPTH);
    check("credit_ready_low", req_ready[0], 0);
    check("credit_busy", busy, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("credit_return_ready", req_ready[0], 1);
    tick();
    check("credit_one_more", acc_log.size(), DEPTH + 1);
    repeat (5) tick();
    check("credit_no_extra", acc_log.size(), DEPTH + 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("credit_idle");

    // --- random traffic, rsp_ready toggling every cycle ---
    do_reset();
    s0 = rsp_seen;
    a0 = acc_log.size();
    phase = 1'($urandom);
    for (int c = 0; c < 400; c++) begin
      rsp_ready = phase ^ c[0];
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) != 0)
          set_req(i, 1'b1, 2'($urandom_range(0, 3)), STAGES'($urandom), $urandom);
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("rand_idle");
    check("rand_no_loss", rsp_seen - s0, acc_log.size() - a0);
    check("rand_model_empty", mq.size(), 0);

    // --- reset with 3 in flight and 2 queued ---
    do_reset();
    acc_log.delete();
    set_req(0, 1'b1, 2'b00, 5'd1, 32'h5);
    n = 0;
    while (acc_log.size() < 5 && n < 30) begin
      tick();
      n++;
    end
    req_valid = '0;
    check("rst_accepts", acc_log.size(), 5);
    repeat (4) tick();
    check("rst_pre_valid", rsp_valid, 1);
    check("rst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", rsp_valid, 0);
    check("rst_async_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    s0 = rsp_seen;
    vseen = 0;
    repeat (15) begin
      tick();
      if (rsp_valid) vseen++;
    end
    check("rst_no_stale_valid", vseen, 0);
    check("rst_no_stale_pop", rsp_seen - s0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
